axi_wr_arbiter: RTL and testbench

- Two-master write-channel arbiter for the 2-master/2-slave AXI interconnect.
- Selects one master's write-address request and forwards it to the address-decode/slave path.
- Holds the grant until the matching write response (B) handshake completes.
- Sits between the master ports and the address decoder that splits the space into slave 1 and slave 2 at 0x200.

---
 rtl/axi_ic_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 24 ++
 rtl/axi_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// Shared definitions for the 2-master/2-slave AXI interconnect:
// write/read arbiter state encoding, default bus width and the
// slave address boundary used by the address decoder.
package axi_ic_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int DEF_ADDR_WIDTH = 32;

    // Addresses below this go to slave 1, at or above go to slave 2.
    localparam logic [31:0] S1_WIDTH = 32'h0000_0200;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-requester round-robin arbiter.
// i_ptr selects which master is favoured when both request:
// 0 = master 0 wins a tie, 1 = master 1 wins a tie.
// Shared by the write- and read-channel arbiters.
module rr_arbiter2
    import axi_ic_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    // One-hot winner from the request vector and tie-break pointer
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write-channel arbiter. Grants one master's AW request,
// forwards it to the decoder path and holds the grant until the matching
// B handshake completes.
// Optional watchdog: define AXI_WR_ARB_WDT_EN to abort a transaction that
// stays in ADDR/RESP for WDT_CYCLES cycles (wdt_err pulses once).
//
// state | meaning
// IDLE  | no owner, arbitrate pending requests
// ADDR  | owner's AW forwarded to the slave path
// RESP  | waiting for B handshake with owner
module axi_wr_arbiter
    import axi_ic_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WDT_CYCLES = 256,
    parameter int WDT_CNT_W  = 9
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] m0_awaddr,
    input  logic                  m0_awvalid,
    output logic                  m0_awready,
    output logic                  m0_bvalid,
    input  logic                  m0_bready,
    input  logic [ADDR_WIDTH-1:0] m1_awaddr,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    output logic [ADDR_WIDTH-1:0] s_awaddr,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  wdt_err
);

    if (WDT_CYCLES < 1 || WDT_CYCLES >= (1 << WDT_CNT_W)) begin : g_bad_wdt_cfg
        $error("axi_wr_arbiter: WDT_CNT_W too narrow for WDT_CYCLES");
    end

    logic [1:0] r_state;
    logic [1:0] r_grant;
    logic       r_ptr;
    logic [1:0] w_win;
    logic       w_b_done;
    logic       w_wdt_expire;
    logic       w_release;

    rr_arbiter2 u_rr (
        .i_req (({m1_awvalid, m0_awvalid})),
        .i_ptr (r_ptr),
        .o_gnt (w_win)
    );

    assign w_b_done  = (r_state == ST_RESP) && s_bvalid && s_bready;
    assign w_release = w_b_done || w_wdt_expire;

`ifdef AXI_WR_ARB_WDT_EN
    logic [WDT_CNT_W-1:0] r_wdt_cnt;
    logic                 r_wdt_err;

    assign w_wdt_expire = (r_state != ST_IDLE) &&
                          (r_wdt_cnt == WDT_CNT_W'(WDT_CYCLES - 1));
    assign wdt_err      = r_wdt_err;

    // Watchdog: held at zero in IDLE, counts every ADDR/RESP cycle;
    // a real B handshake on the expiry cycle wins and suppresses the error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdt_cnt <= '0;
            r_wdt_err <= 1'b0;
        end else begin
            r_wdt_err <= w_wdt_expire && !w_b_done;
            if (r_state == ST_IDLE) begin
                r_wdt_cnt <= '0;
            end else begin
                r_wdt_cnt <= r_wdt_cnt + 1'b1;
            end
        end
    end
`else
    assign w_wdt_expire = 1'b0;
    assign wdt_err      = 1'b0;
`endif

    // Arbitration FSM: grant captured in IDLE, released after B or watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_ptr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m0_awvalid || m1_awvalid) begin
                        r_grant <= w_win;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_release) begin
                        r_ptr   <= r_grant[0];
                        r_grant <= 2'b00;
                        r_state <= ST_IDLE;
                    end else if (s_awvalid && s_awready) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_release) begin
                        r_ptr   <= r_grant[0];
                        r_grant <= 2'b00;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_grant <= 2'b00;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Channel steering: only the owner sees ready/response, everything 0 in IDLE
    always_comb begin
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_bready   = 1'b0;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_bvalid  = 1'b0;
        m1_bvalid  = 1'b0;
        if (r_grant[0]) begin
            s_awaddr = m0_awaddr;
        end else if (r_grant[1]) begin
            s_awaddr = m1_awaddr;
        end
        if (r_state == ST_ADDR) begin
            s_awvalid  = (r_grant[0] && m0_awvalid) || (r_grant[1] && m1_awvalid);
            m0_awready = r_grant[0] && s_awready;
            m1_awready = r_grant[1] && s_awready;
        end
        if (r_state == ST_RESP) begin
            s_bready  = (r_grant[0] && m0_bready) || (r_grant[1] && m1_bready);
            m0_bvalid = r_grant[0] && s_bvalid;
            m1_bvalid = r_grant[1] && s_bvalid;
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter. The watchdog section runs only when
// AXI_WR_ARB_WDT_EN is defined for the build.
module tb_axi_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] m0_awaddr, m1_awaddr, s_awaddr;
    logic        m0_awvalid, m0_awready, m0_bvalid, m0_bready;
    logic        m1_awvalid, m1_awready, m1_bvalid, m1_bready;
    logic        s_awvalid, s_awready, s_bvalid, s_bready;
    logic [1:0]  grant;
    logic        busy, wdt_err;

    int n_chk  = 0;
    int n_pass = 0;

    axi_wr_arbiter #(.ADDR_WIDTH(32), .WDT_CYCLES(16), .WDT_CNT_W(9)) dut (
        .clk(clk), .rst(rst),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant), .busy(busy), .wdt_err(wdt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change 2 time units after the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Request already pending in IDLE; runs it through ADDR/RESP with no stalls
    task automatic txn(input logic [1:0] exp_gnt, input logic [31:0] exp_addr);
        step();
        s_awready = 1'b1;
        #1;
        chk("txn_grant", grant, exp_gnt);
        chk("txn_addr", s_awaddr, exp_addr);
        chk("txn_awready", {m1_awready, m0_awready}, exp_gnt);
        step();
        s_awready = 1'b0;
        if (exp_gnt[0]) m0_awvalid = 1'b0; else m1_awvalid = 1'b0;
        s_bvalid  = 1'b1;
        m0_bready = 1'b1;
        m1_bready = 1'b1;
        #1;
        chk("txn_bvalid", {m1_bvalid, m0_bvalid}, exp_gnt);
        step();
        s_bvalid  = 1'b0;
        m0_bready = 1'b0;
        m1_bready = 1'b0;
        #1;
        chk("txn_idle", {busy, grant}, 3'b000);
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        m0_awaddr = '0; m1_awaddr = '0;
        m0_awvalid = 0; m1_awvalid = 0; m0_bready = 0; m1_bready = 0;
        s_awready = 0; s_bvalid = 0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_outs", {s_awvalid, s_bready, m0_awready, m1_awready, m0_bvalid, m1_bvalid}, 6'd0);
        chk("rst_addr", s_awaddr, 32'h0);

        // Single request from master 0
        m0_awvalid = 1'b1; m0_awaddr = 32'h0000_0100;
        #1;
        chk("idle_no_ready", {m0_awready, busy}, 2'b00);
        step();
        s_awready = 1'b1;
        #1;
        chk("s1_grant", grant, 2'b01);
        chk("s1_addr", s_awaddr, 32'h100);
        chk("s1_awvalid", s_awvalid, 1'b1);
        chk("s1_awready", {m1_awready, m0_awready}, 2'b01);
        step();
        s_awready = 1'b0; m0_awvalid = 1'b0;
        #1;
        chk("s1_resp", {busy, s_awvalid, m0_awready}, 3'b100);
        s_bvalid = 1'b1; m0_bready = 1'b1;
        #1;
        chk("s1_bvalid", {m1_bvalid, m0_bvalid, s_bready}, 3'b011);
        step();
        s_bvalid = 1'b0; m0_bready = 1'b0;
        #1;
        chk("s1_idle", {busy, grant}, 3'b000);

        // Simultaneous requests from reset: m0, m1, then m0 again
        rst = 1'b1; step(); rst = 1'b0;
        m0_awvalid = 1'b1; m0_awaddr = 32'h10;
        m1_awvalid = 1'b1; m1_awaddr = 32'h300;
        txn(2'b01, 32'h10);
        txn(2'b10, 32'h300);
        m0_awvalid = 1'b1; m1_awvalid = 1'b1;
        txn(2'b01, 32'h10);
        m1_awvalid = 1'b0;

        // Late request from m1 while m0 sits in RESP
        m0_awvalid = 1'b1; m0_awaddr = 32'h20;
        step();
        s_awready = 1'b1;
        step();
        s_awready = 1'b0; m0_awvalid = 1'b0;
        m1_awvalid = 1'b1; m1_awaddr = 32'h340;
        #1;
        chk("late_wait0", {grant, m1_awready}, 3'b010);
        step();
        #1;
        chk("late_wait1", {busy, m1_awready}, 2'b10);
        s_bvalid = 1'b1; m0_bready = 1'b1;
        #1;
        chk("late_wait2", {m0_bvalid, m1_awready}, 2'b10);
        step();
        s_bvalid = 1'b0; m0_bready = 1'b0;
        #1;
        chk("late_idle", {busy, grant, m1_awready}, 4'b0000);
        step();
        s_awready = 1'b1;
        #1;
        chk("late_grant", {grant, m1_awready, m0_awready}, 4'b1010);
        chk("late_addr", s_awaddr, 32'h340);
        step();
        s_awready = 1'b0; m1_awvalid = 1'b0;
        s_bvalid = 1'b1; m1_bready = 1'b1;
        #1;
        chk("late_bvalid", {m1_bvalid, m0_bvalid}, 2'b10);
        step();
        s_bvalid = 1'b0; m1_bready = 1'b0;

        // Back-pressure: 5 cycles of s_awready=0, then 3 cycles of m0_bready=0
        m0_awvalid = 1'b1; m0_awaddr = 32'h1F0;
        step();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (grant !== 2'b01 || s_awaddr !== 32'h1F0 || m0_awready !== 1'b0 ||
                s_awvalid !== 1'b1 || busy !== 1'b1) bad++;
            step();
        end
        chk("bp_addr_stall", bad, 0);
        s_awready = 1'b1;
        #1;
        chk("bp_awready", m0_awready, 1'b1);
        step();
        s_awready = 1'b0; m0_awvalid = 1'b0;
        s_bvalid = 1'b1; m0_bready = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (grant !== 2'b01 || s_awaddr !== 32'h1F0 || s_bready !== 1'b0 ||
                m0_bvalid !== 1'b1 || m0_awready !== 1'b0 || s_awvalid !== 1'b0) bad++;
            step();
        end
        chk("bp_resp_stall", bad, 0);
        m0_bready = 1'b1;
        #1;
        chk("bp_bready", s_bready, 1'b1);
        step();
        s_bvalid = 1'b0; m0_bready = 1'b0;
        #1;
        chk("bp_idle", {busy, grant}, 3'b000);

        // Reset in RESP while m1 owns the bus
        m1_awvalid = 1'b1; m1_awaddr = 32'h300;
        step();
        s_awready = 1'b1;
        step();
        s_awready = 1'b0; m1_awvalid = 1'b0;
        s_bvalid = 1'b1; m1_bready = 1'b0;
        #1;
        chk("mr_pre", {busy, grant}, 3'b110);
        rst = 1'b1;
        step();
        rst = 1'b0; m1_bready = 1'b1;
        #1;
        chk("mr_state", {busy, grant}, 3'b000);
        chk("mr_outs", {s_awvalid, s_bready, m0_awready, m1_awready, m0_bvalid, m1_bvalid}, 6'd0);
        s_bvalid = 1'b0; m1_bready = 1'b0;
        m0_awvalid = 1'b1; m0_awaddr = 32'h10;
        m1_awvalid = 1'b1; m1_awaddr = 32'h300;
        txn(2'b01, 32'h10);
        m1_awvalid = 1'b0;

`ifdef AXI_WR_ARB_WDT_EN
        // Watchdog: m0 never receives B, m1 waits behind it
        rst = 1'b1; step(); rst = 1'b0;
        m0_awvalid = 1'b1; m0_awaddr = 32'h40;
        step();
        s_awready = 1'b1;
        step();
        s_awready = 1'b0; m0_awvalid = 1'b0;
        m1_awvalid = 1'b1; m1_awaddr = 32'h300;
        bad = 0;
        for (int k = 2; k <= 16; k++) begin
            #1;
            if (wdt_err !== 1'b0 || grant !== 2'b01) bad++;
            step();
        end
        chk("wdt_quiet", bad, 0);
        #1;
        chk("wdt_pulse", {wdt_err, busy, grant}, 4'b1000);
        step();
        #1;
        chk("wdt_next", {wdt_err, busy, grant}, 4'b0110);
        m1_awvalid = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
